// File: rtl/demux1_2_stream.sv
// ---------------------------------------------------------------------------
// demux1_2_stream
//   Registered 1-to-2 stream demultiplexer with valid/ready handshakes. Each
//   accepted word is steered by its select bit into one of two 2-entry FIFOs.
//   The FIFOs are independent, so a stalled consumer never blocks the other.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous clear of both FIFOs (beats push/pop)
//   in_data/in_sel      offered word and its destination (0 -> out0, 1 -> out1)
//   in_valid/in_ready   producer handshake
//   outX_data/valid     head word of FIFO X and its non-empty flag
//   outX_ready          consumer X pops the head word this cycle
//   cnt0/cnt1           occupancy of each FIFO (0..2)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// demux_fifo2
//   2-entry FIFO whose occupancy is held directly as the FSM state. The head
//   word is kept in its own register so it holds its last value once the FIFO
//   drains, and reads 0 after reset or flush.
//
// Ports
//   clk, rst_n, flush   as in the top level
//   push_i, wdata_i     write request and word (ignored while FULL)
//   pop_i               read request (ignored while EMPTY)
//   rdata_o, valid_o    head word and non-empty flag
//   full_o, cnt_o       full flag and occupancy
//
//   state | meaning
//   EMPTY | no words buffered, valid_o=0
//   ONE   | one word buffered, head at rd_ptr
//   FULL  | two words buffered, pushes refused even if a pop happens
// ---------------------------------------------------------------------------
module demux_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          valid_o,
    output logic          full_o,
    output logic [1:0]    cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] head_q, head_d;
    logic          do_push;
    logic          do_pop;

    // Qualified events: flush voids anything requested in the same cycle.
    always_comb begin
        do_push = push_i & (state_q != FULL) & ~flush;
        do_pop  = pop_i & (state_q != EMPTY) & ~flush;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (do_push) state_d = ONE;
                end
                ONE: begin
                    if (do_push && !do_pop)      state_d = FULL;
                    else if (!do_push && do_pop) state_d = EMPTY;
                end
                FULL: begin
                    if (do_pop) state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Output logic
    always_comb begin
        valid_o = (state_q != EMPTY);
        full_o  = (state_q == FULL);
        cnt_o   = state_q;
        rdata_o = head_q;
    end

    // Pointer and head-word next values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            head_d   = '0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            // The new head may be the word being written this very cycle.
            if (state_d != EMPTY) begin
                if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                    head_d = wdata_i;
                end else begin
                    head_d = mem_q[rd_ptr_d];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            head_q   <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

endmodule

module demux1_2_stream #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [DW-1:0] in_data,
    input  logic          in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out0_data,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [DW-1:0] out1_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [1:0]    cnt0,
    output logic [1:0]    cnt1
);

    logic full0;
    logic full1;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    // in_ready follows in_sel combinationally; the producer keeps in_sel
    // stable while valid, so this never forms a handshake loop.
    always_comb begin
        in_ready = rst_n & ~flush & (in_sel ? ~full1 : ~full0);
        push0    = in_valid & in_ready & ~in_sel;
        push1    = in_valid & in_ready & in_sel;
        pop0     = out0_valid & out0_ready;
        pop1     = out1_valid & out1_ready;
    end

    demux_fifo2 #(.DW(DW)) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push_i  (push0),
        .wdata_i (in_data),
        .pop_i   (pop0),
        .rdata_o (out0_data),
        .valid_o (out0_valid),
        .full_o  (full0),
        .cnt_o   (cnt0)
    );

    demux_fifo2 #(.DW(DW)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push_i  (push1),
        .wdata_i (in_data),
        .pop_i   (pop1),
        .rdata_o (out1_data),
        .valid_o (out1_valid),
        .full_o  (full1),
        .cnt_o   (cnt1)
    );

endmodule

// File: tb/tb_demux1_2_stream.sv
module tb_demux1_2_stream;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out0_data;
    logic          out0_valid;
    logic          out0_ready;
    logic [DW-1:0] out1_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [1:0]    cnt0;
    logic [1:0]    cnt1;

    demux1_2_stream #(.DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per destination, capacity 2, plus the last
    // head word each output showed (0 after reset/flush).
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] last0, last1;
    logic          accepted;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
    endtask

    // One clock cycle: check outputs against the model at the falling edge,
    // then advance the model by what the rising edge does.
    task automatic tick();
        logic exp_rdy, acc, p0, p1;
        @(negedge clk);
        exp_rdy = rst_n && !flush && (in_sel ? (q1.size() != 2) : (q0.size() != 2));
        chk("in_ready",   {31'b0, in_ready},   {31'b0, exp_rdy});
        chk("out0_valid", {31'b0, out0_valid}, (q0.size() != 0) ? 1 : 0);
        chk("out1_valid", {31'b0, out1_valid}, (q1.size() != 0) ? 1 : 0);
        chk("cnt0",       {30'b0, cnt0},       q0.size());
        chk("cnt1",       {30'b0, cnt1},       q1.size());
        chk("out0_data",  {24'b0, out0_data},  {24'b0, last0});
        chk("out1_data",  {24'b0, out1_data},  {24'b0, last1});
        acc = in_valid && exp_rdy;
        p0  = (q0.size() != 0) && out0_ready;
        p1  = (q1.size() != 0) && out1_ready;
        @(posedge clk);
        #1;
        accepted = acc;
        if (!rst_n || flush) begin
            model_clear();
        end else begin
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (acc) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
            if (q0.size() != 0) last0 = q0[0];
            if (q1.size() != 0) last1 = q1[0];
        end
    endtask

    task automatic offer(input logic [DW-1:0] d, input logic s);
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0; accepted = 1'b0;
        model_clear();
        repeat (2) tick();
        chk("reset_out0_data", {24'b0, out0_data}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1. Reset mid-stream with two words in FIFO0
        offer(8'h11, 1'b0); tick();
        offer(8'h22, 1'b0); tick();
        in_valid = 1'b0;
        chk("t1_cnt0_full", {30'b0, cnt0}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_valid0", {31'b0, out0_valid}, 32'd0);
        chk("t1_rst_cnt0",   {30'b0, cnt0},       32'd0);
        chk("t1_rst_ready",  {31'b0, in_ready},   32'd0);
        model_clear();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t1_ready_after", {31'b0, in_ready}, 32'd1);

        // 2. Routing
        out0_ready = 1'b1; out1_ready = 1'b1;
        offer(8'hA5, 1'b0); tick();
        chk("t2_out0_data", {24'b0, out0_data}, 32'hA5);
        offer(8'h3C, 1'b1); tick();
        chk("t2_out0_gone", {31'b0, out0_valid}, 32'd0);
        chk("t2_out1_data", {24'b0, out1_data}, 32'h3C);
        in_valid = 1'b0; tick();
        chk("t2_out1_gone", {31'b0, out1_valid}, 32'd0);
        tick();

        // 3. Backpressure
        out0_ready = 1'b0;
        offer(8'h01, 1'b0); tick();
        offer(8'h02, 1'b0); tick();
        offer(8'h03, 1'b0); #1;
        chk("t3_ready_full", {31'b0, in_ready}, 32'd0);
        chk("t3_cnt0", {30'b0, cnt0}, 32'd2);
        tick();
        chk("t3_head", {24'b0, out0_data}, 32'h01);

        // 4. Independence: FIFO0 stalled full, FIFO1 still accepts
        offer(8'h77, 1'b1); #1;
        chk("t4_ready_sel1", {31'b0, in_ready}, 32'd1);
        tick();
        chk("t4_out1_data", {24'b0, out1_data}, 32'h77);
        chk("t4_cnt0_held", {30'b0, cnt0}, 32'd2);
        in_valid = 1'b0; tick();

        // 5. Full pop without bypass, then push while popping (word 03 pending)
        offer(8'h03, 1'b0); out0_ready = 1'b1; #1;
        chk("t5_no_bypass", {31'b0, in_ready}, 32'd0);
        tick();
        chk("t5_cnt0_one", {30'b0, cnt0}, 32'd1);
        chk("t5_head02", {24'b0, out0_data}, 32'h02);
        tick();
        chk("t5_cnt0_stay", {30'b0, cnt0}, 32'd1);
        chk("t5_head03", {24'b0, out0_data}, 32'h03);
        in_valid = 1'b0; tick(); tick();

        // 6. Flush with both FIFOs holding words
        out0_ready = 1'b0; out1_ready = 1'b0;
        offer(8'h44, 1'b0); tick();
        offer(8'h55, 1'b1); tick();
        offer(8'h66, 1'b0); flush = 1'b1; #1;
        chk("t6_ready_flush", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t6_cnt0", {30'b0, cnt0}, 32'd0);
        chk("t6_cnt1", {30'b0, cnt1}, 32'd0);
        chk("t6_data0_zero", {24'b0, out0_data}, 32'h0);
        tick();

        // Randomized traffic against the queue model
        accepted = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = DW'($urandom);
                in_sel   = $urandom_range(0, 1) == 1;
            end
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 29) == 0);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
